// File: rtl/my_cpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// my_cpu_sequencer_if
// Purpose : bundles the handshake and control signals between the Hack CPU
//           fetch/execute sequencer and the surrounding datapath (instruction
//           ROM, data RAM, my_pc, A/D registers, ALU).
// Signals :
//   instr[15:0]   ROM data                    (datapath -> sequencer)
//   instr_valid   ROM data valid this cycle   (datapath -> sequencer)
//   zr, ng        ALU zero / negative flags   (datapath -> sequencer)
//   mem_ack       RAM accepted the write      (datapath -> sequencer)
//   fetch_req     request instruction at PC   (sequencer -> datapath)
//   pc_reset/pc_load/pc_inc   my_pc controls  (sequencer -> datapath)
//   a_load, a_sel, d_load     register loads and A input select
//   am_sel, alu_ctrl[5:0]     ALU y select and zx nx zy ny f no
//   mem_write     RAM write strobe
//   fault         sticky fetch-timeout flag
//   state[2:0]    debug view of the sequencer FSM
// Modports: master = sequencer side, slave = datapath side.
// -----------------------------------------------------------------------------
interface my_cpu_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        zr;
  logic        ng;
  logic        mem_ack;
  logic        fetch_req;
  logic        pc_reset;
  logic        pc_load;
  logic        pc_inc;
  logic        a_load;
  logic        a_sel;
  logic        d_load;
  logic        am_sel;
  logic [5:0]  alu_ctrl;
  logic        mem_write;
  logic        fault;
  logic [2:0]  state;

  modport master (
    input  instr, instr_valid, zr, ng, mem_ack,
    output fetch_req, pc_reset, pc_load, pc_inc, a_load, a_sel, d_load,
           am_sel, alu_ctrl, mem_write, fault, state
  );

  modport slave (
    output instr, instr_valid, zr, ng, mem_ack,
    input  fetch_req, pc_reset, pc_load, pc_inc, a_load, a_sel, d_load,
           am_sel, alu_ctrl, mem_write, fault, state
  );
endinterface

// File: rtl/my_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// my_cpu_sequencer
// Purpose : multi-cycle fetch/execute controller for the Hack CPU. Holds the
//           instruction register, drives my_pc (reset/load/inc), A/D loads,
//           ALU control and the RAM write strobe. At most one of
//           pc_reset/pc_load/pc_inc is high in any cycle.
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous active-high reset (overrides every state)
//   step   (only with MY_CPU_SEQUENCER_STEP_EN) advance out of S_IDLE
//   bus    my_cpu_sequencer_if.master, see interface header
// Parameters:
//   RESET_HOLD    cycles pc_reset stays high after reset deasserts (>=1)
//   FETCH_TIMEOUT cycles in S_FETCH without instr_valid before S_FAULT (>=1)
// Configuration macro: MY_CPU_SEQUENCER_STEP_EN adds the step input and the
//   S_IDLE single-step state; undefined gives a free-running sequencer.
// -----------------------------------------------------------------------------
module my_cpu_sequencer #(
  parameter int RESET_HOLD    = 2,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
`ifdef MY_CPU_SEQUENCER_STEP_EN
  input  logic step,
`endif
  my_cpu_sequencer_if.master bus
);

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;
`ifdef MY_CPU_SEQUENCER_STEP_EN
  localparam logic [2:0] S_IDLE  = 3'd5;
  // After a commit (or reset hold) wait for a step pulse.
  localparam logic [2:0] S_AFTER = S_IDLE;
`else
  localparam logic [2:0] S_AFTER = S_FETCH;
`endif

  localparam int CNT_MAX = (RESET_HOLD > FETCH_TIMEOUT) ? RESET_HOLD : FETCH_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [15:0]   r_ir;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_fault;
  logic          w_fault_next;
  logic          w_jump;
  logic          w_unused_ir;

  // Jump field of a C-instruction, evaluated against the live ALU flags.
  assign w_jump = (r_ir[2] & bus.ng) | (r_ir[1] & bus.zr) |
                  (r_ir[0] & ~bus.ng & ~bus.zr);

  // IR[14:13] are fixed ones in Hack C-instructions and carry no control.
  assign w_unused_ir = &{1'b0, r_ir[14:13]};

  // State register, IR, shared hold/timeout counter and sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RST;
      r_ir    <= 16'h0000;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_fault <= w_fault_next;
      if (r_state == S_FETCH && bus.instr_valid)
        r_ir <= bus.instr;
    end
  end

  // Next-state logic. The counter defaults to zero so every state change
  // clears it; only S_RST and a waiting S_FETCH advance it.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_fault_next = r_fault;
    case (r_state)
      S_RST: begin
        if (r_cnt == CW'(RESET_HOLD - 1))
          w_state_next = S_AFTER;
        else
          w_cnt_next = r_cnt + 1'b1;
      end
      S_FETCH: begin
        if (bus.instr_valid) begin
          w_state_next = S_EXEC;
        end else if (r_cnt == CW'(FETCH_TIMEOUT - 1)) begin
          w_state_next = S_FAULT;
          w_fault_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_EXEC: begin
        if (r_ir[15] && r_ir[3])
          w_state_next = S_MEM;
        else
          w_state_next = S_AFTER;
      end
      S_MEM: begin
        if (bus.mem_ack)
          w_state_next = S_AFTER;
      end
      S_FAULT: w_state_next = S_FAULT;
`ifdef MY_CPU_SEQUENCER_STEP_EN
      S_IDLE: begin
        if (step)
          w_state_next = S_FETCH;
      end
`endif
      default: w_state_next = S_RST;
    endcase
  end

  // Output decode from state and IR.
  always_comb begin
    bus.fetch_req = 1'b0;
    bus.pc_reset  = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.a_load    = 1'b0;
    bus.a_sel     = 1'b0;
    bus.d_load    = 1'b0;
    bus.am_sel    = 1'b0;
    bus.alu_ctrl  = 6'd0;
    bus.mem_write = 1'b0;
    bus.fault     = 1'b0;
    bus.state     = r_state;
    case (r_state)
      S_RST:   bus.pc_reset  = 1'b1;
      S_FETCH: bus.fetch_req = 1'b1;
      S_EXEC: begin
        if (!r_ir[15]) begin
          bus.a_load = 1'b1;
          bus.pc_inc = 1'b1;
        end else begin
          bus.a_sel    = 1'b1;
          bus.am_sel   = r_ir[12];
          bus.alu_ctrl = r_ir[11:6];
          if (r_ir[3]) begin
            // RAM write first: A/D/PC stay put so addressM is the old A.
            bus.mem_write = 1'b1;
          end else begin
            bus.a_load  = r_ir[5];
            bus.d_load  = r_ir[4];
            bus.pc_load = w_jump;
            bus.pc_inc  = ~w_jump;
          end
        end
      end
      S_MEM: begin
        bus.mem_write = 1'b1;
        bus.a_sel     = 1'b1;
        bus.am_sel    = r_ir[12];
        bus.alu_ctrl  = r_ir[11:6];
        if (bus.mem_ack) begin
          bus.a_load  = r_ir[5];
          bus.d_load  = r_ir[4];
          bus.pc_load = w_jump;
          bus.pc_inc  = ~w_jump;
        end
      end
      S_FAULT: bus.fault = r_fault;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_my_cpu_sequencer.sv
module tb_my_cpu_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_mw     = 0;

  my_cpu_sequencer_if bus ();

  my_cpu_sequencer #(.RESET_HOLD(2), .FETCH_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {fetch_req,pc_reset,pc_load,pc_inc,a_load,a_sel,d_load,am_sel,mem_write,fault}
  logic [9:0] outs;
  assign outs = {bus.fetch_req, bus.pc_reset, bus.pc_load, bus.pc_inc, bus.a_load,
                 bus.a_sel, bus.d_load, bus.am_sel, bus.mem_write, bus.fault};

  localparam logic [9:0] O_RST   = 10'b0100000000;
  localparam logic [9:0] O_FETCH = 10'b1000000000;
  localparam logic [9:0] O_AEX   = 10'b0001100000;
  localparam logic [9:0] O_JMP   = 10'b0010010000;
  localparam logic [9:0] O_NOJMP = 10'b0001010000;
  localparam logic [9:0] O_MW    = 10'b0000010010;
  localparam logic [9:0] O_MWACK = 10'b0001010010;
  localparam logic [9:0] O_FAULT = 10'b0000000001;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.instr = 16'h0000;
    bus.instr_valid = 1'b0;
    bus.zr = 1'b0;
    bus.ng = 1'b0;
    bus.mem_ack = 1'b0;

    // 1: one reset edge, then pc_reset for two cycles, then fetch.
    cyc();
    reset = 1'b0;
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_outs1", 32'(outs), 32'(O_RST));
    check("rst_alu", 32'(bus.alu_ctrl), 32'd0);
    cyc(); #1;
    check("rst_outs2", 32'(outs), 32'(O_RST));
    cyc(); #1;
    check("fetch_state", 32'(bus.state), 32'd1);
    check("fetch_outs", 32'(outs), 32'(O_FETCH));
    $display("txn reset release done");

    // 2: A-instruction @5 accepted on first fetch cycle.
    bus.instr = 16'h0005; bus.instr_valid = 1'b1;
    cyc(); bus.instr_valid = 1'b0; #1;
    check("aex_state", 32'(bus.state), 32'd2);
    check("aex_outs", 32'(outs), 32'(O_AEX));
    check("aex_alu", 32'(bus.alu_ctrl), 32'd0);
    cyc(); #1;
    check("aex_back", 32'(bus.state), 32'd1);
    $display("txn A-instr 0x0005 done");

    // 3: D;JGT with positive then zero flags.
    bus.instr = 16'hE301; bus.instr_valid = 1'b1;
    cyc(); bus.instr_valid = 1'b0; bus.instr = 16'hFFFF; #1;
    check("jgt_taken", 32'(outs), 32'(O_JMP));
    check("jgt_alu", 32'(bus.alu_ctrl), 32'h0C);
    bus.zr = 1'b1; #1;
    check("jgt_not_taken", 32'(outs), 32'(O_NOJMP));
    bus.zr = 1'b0; bus.ng = 1'b1; #1;
    check("jgt_neg", 32'(outs), 32'(O_NOJMP));
    bus.ng = 1'b0;
    cyc(); #1;
    check("jgt_back", 32'(bus.state), 32'd1);
    $display("txn C-instr 0xE301 done");

    // 4: M=D, mem_ack on third S_MEM cycle; stray instr_valid ignored.
    bus.instr = 16'hE308; bus.instr_valid = 1'b1;
    cyc(); bus.instr_valid = 1'b0; #1;
    check("mw_exec", 32'(outs), 32'(O_MW));
    n_mw += int'(bus.mem_write);
    bus.instr_valid = 1'b1;
    cyc(); #1;
    check("mw_mem1_state", 32'(bus.state), 32'd3);
    check("mw_mem1", 32'(outs), 32'(O_MW));
    n_mw += int'(bus.mem_write);
    bus.instr_valid = 1'b0;
    cyc(); #1;
    check("mw_mem2", 32'(outs), 32'(O_MW));
    n_mw += int'(bus.mem_write);
    cyc();
    bus.mem_ack = 1'b1; #1;
    check("mw_ack", 32'(outs), 32'(O_MWACK));
    n_mw += int'(bus.mem_write);
    cyc(); bus.mem_ack = 1'b0; #1;
    check("mw_len", 32'(n_mw), 32'd4);
    check("mw_back", 32'(outs), 32'(O_FETCH));
    $display("txn M-write 0xE308 done");

    // 5: fetch timeout after 16 cycles without instr_valid.
    for (int i = 0; i < 15; i++) cyc();
    #1;
    check("to_before", 32'(bus.state), 32'd1);
    cyc(); #1;
    check("to_state", 32'(bus.state), 32'd4);
    check("to_outs", 32'(outs), 32'(O_FAULT));
    bus.instr_valid = 1'b1; bus.mem_ack = 1'b1;
    cyc(); #1;
    check("to_sticky", 32'(bus.state), 32'd4);
    bus.instr_valid = 1'b0; bus.mem_ack = 1'b0;
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    check("to_reset_state", 32'(bus.state), 32'd0);
    check("to_reset_outs", 32'(outs), 32'(O_RST));
    $display("txn fetch timeout done");

    // 6: reset during S_MEM, with mem_ack high, wins.
    cyc(); cyc();
    bus.instr = 16'hE338; bus.instr_valid = 1'b1;
    cyc(); bus.instr_valid = 1'b0;
    cyc(); #1;
    check("rm_in_mem", 32'(bus.state), 32'd3);
    reset = 1'b1; bus.mem_ack = 1'b1;
    cyc(); #1;
    check("rm_state", 32'(bus.state), 32'd0);
    check("rm_outs", 32'(outs), 32'(O_RST));
    reset = 1'b0; bus.mem_ack = 1'b0;
    $display("txn reset in S_MEM done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
